// File: rtl/cv32e40x_rd_fifo_arb_pkg.sv
// Shared types for the ID-stage rd-packet FIFO and its front-end arbiter.
// Packet layout is owned by the ID stage; the arbiter treats it as opaque payload.
package cv32e40x_pkg;

  typedef struct packed {
    logic [7:0] instr_tag;
    logic       rd_we;
    logic [4:0] rd_addr;
    logic [1:0] src_id;
  } id_rd_packet_t;

  typedef enum logic [1:0] {
    RD_ARB_RUN   = 2'd0,
    RD_ARB_FLUSH = 2'd1,
    RD_ARB_DRAIN = 2'd2,
    RD_ARB_DONE  = 2'd3
  } rd_fifo_arb_state_e;

  localparam int RD_FIFO_ARB_MAX_REQ = 8;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cv32e40x_rd_fifo_arb_rr.sv
// Generic round-robin picker: first valid at or after the pointer, wrapping.
// Grant is combinational; the pointer moves past the winner only when enabled.
module cv32e40x_rr_arbiter #(
  parameter  int N     = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     valid_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] gnt_idx_o
);

  logic [PTR_W-1:0] r_ptr;
  logic [N-1:0]     w_gnt;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    int j;
    j       = 0;
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N) j = j - N;
      if (!w_found && valid_i[j]) begin
        w_found  = 1'b1;
        w_gnt[j] = 1'b1;
        w_idx    = PTR_W'(j);
      end
    end
  end

  assign gnt_o     = en_i ? w_gnt : '0;
  assign gnt_idx_o = w_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (en_i && w_found) begin
      r_ptr <= (w_idx == PTR_W'(N - 1)) ? '0 : w_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/cv32e40x_rd_fifo_arb.sv
// Shares the rd-packet FIFO push port among N_REQ producers; turns kills into flush pulses and
// sequences drain for halt/debug. Optional counters under CV32E40X_RD_FIFO_ARB_STATS_EN.
module cv32e40x_rd_fifo_arb
  import cv32e40x_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic          [N_REQ-1:0]       req_valid_i,
  input  id_rd_packet_t [N_REQ-1:0]       req_data_i,
  output logic          [N_REQ-1:0]       req_gnt_o,
  output logic                            fifo_push_o,
  output id_rd_packet_t                   fifo_data_o,
  input  logic                            fifo_full_i,
  input  logic                            fifo_empty_i,
  output logic                            fifo_flush_o,
  output logic                            fifo_flush_but_first_o,
  input  logic                            kill_i,
  input  logic                            kill_keep_first_i,
  input  logic                            drain_req_i,
  output logic                            drain_done_o,
  output logic          [1:0]             state_o
`ifdef CV32E40X_RD_FIFO_ARB_STATS_EN
  ,
  output logic          [N_REQ-1:0][31:0] stat_grant_cnt_o,
  output logic          [31:0]            stat_full_stall_cnt_o,
  output logic          [15:0]            stat_kill_cnt_o
`endif
);

  rd_fifo_arb_state_e r_state;
  rd_fifo_arb_state_e w_state_nxt;
  logic               r_drain_done;
  logic               w_kill_any;
  logic               w_grant_en;
  logic [PTR_W-1:0]   w_gnt_idx;

  assign w_kill_any = kill_i | kill_keep_first_i;

  // Outputs stay quiet while reset is held, including the kill-to-flush path.
  assign w_grant_en = ~rst_i & (r_state == RD_ARB_RUN) & ~fifo_full_i
                    & ~w_kill_any & ~drain_req_i;

  cv32e40x_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (req_valid_i),
    .en_i      (w_grant_en),
    .gnt_o     (req_gnt_o),
    .gnt_idx_o (w_gnt_idx)
  );

  assign fifo_push_o            = |req_gnt_o;
  assign fifo_data_o            = fifo_push_o ? req_data_i[w_gnt_idx] : '0;
  assign fifo_flush_o           = ~rst_i & kill_i;
  assign fifo_flush_but_first_o = ~rst_i & kill_keep_first_i & ~kill_i;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RD_ARB_RUN: begin
        if (w_kill_any)       w_state_nxt = RD_ARB_FLUSH;
        else if (drain_req_i) w_state_nxt = RD_ARB_DRAIN;
      end
      RD_ARB_FLUSH: w_state_nxt = drain_req_i ? RD_ARB_DRAIN : RD_ARB_RUN;
      // Kills here only flush; the drain sequence keeps its place.
      RD_ARB_DRAIN: if (fifo_empty_i) w_state_nxt = RD_ARB_DONE;
      RD_ARB_DONE:  if (!drain_req_i) w_state_nxt = RD_ARB_RUN;
      default:      w_state_nxt = RD_ARB_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= RD_ARB_RUN;
      r_drain_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain_done <= (w_state_nxt == RD_ARB_DONE);
    end
  end

  assign drain_done_o = r_drain_done;
  assign state_o      = r_state;

`ifdef CV32E40X_RD_FIFO_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] r_grant_cnt;
  logic [31:0]            r_full_stall_cnt;
  logic [15:0]            r_kill_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant_cnt      <= '0;
      r_full_stall_cnt <= '0;
      r_kill_cnt       <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (req_gnt_o[k]) r_grant_cnt[k] <= sat_inc32(r_grant_cnt[k]);
      end
      if ((r_state == RD_ARB_RUN) && (|req_valid_i) && fifo_full_i)
        r_full_stall_cnt <= sat_inc32(r_full_stall_cnt);
      if (w_kill_any) r_kill_cnt <= sat_inc16(r_kill_cnt);
    end
  end

  assign stat_grant_cnt_o      = r_grant_cnt;
  assign stat_full_stall_cnt_o = r_full_stall_cnt;
  assign stat_kill_cnt_o       = r_kill_cnt;
`else
  // Without the counters the block is purely the arbiter and sequencer above.
`endif

endmodule

// File: tb/tb_cv32e40x_rd_fifo_arb.sv
// Directed bench for the rd-FIFO arbiter: a 2-requester instance for sequencing and a
// 4-requester instance for pointer wrap.
module tb_cv32e40x_rd_fifo_arb;
  import cv32e40x_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic          [1:0]       v2;
  id_rd_packet_t [1:0]       d2;
  logic                      full, empty, kill, kkf, drain;
  logic          [1:0]       gnt2;
  logic                      push2, flush2, fbf2, done2;
  id_rd_packet_t             fdata2;
  logic          [1:0]       st2;

  logic          [3:0]       v4;
  id_rd_packet_t [3:0]       d4;
  logic                      zero;
  logic          [3:0]       gnt4;
  logic                      push4, flush4, fbf4, done4;
  id_rd_packet_t             fdata4;
  logic          [1:0]       st4;

`ifdef CV32E40X_RD_FIFO_ARB_STATS_EN
  logic [1:0][31:0] sg2;
  logic [31:0]      ss2;
  logic [15:0]      sk2;
  logic [3:0][31:0] sg4;
  logic [31:0]      ss4;
  logic [15:0]      sk4;
`endif

  cv32e40x_rd_fifo_arb #(.N_REQ(2)) u2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v2), .req_data_i(d2), .req_gnt_o(gnt2),
    .fifo_push_o(push2), .fifo_data_o(fdata2), .fifo_full_i(full), .fifo_empty_i(empty),
    .fifo_flush_o(flush2), .fifo_flush_but_first_o(fbf2), .kill_i(kill),
    .kill_keep_first_i(kkf), .drain_req_i(drain), .drain_done_o(done2), .state_o(st2)
`ifdef CV32E40X_RD_FIFO_ARB_STATS_EN
    , .stat_grant_cnt_o(sg2), .stat_full_stall_cnt_o(ss2), .stat_kill_cnt_o(sk2)
`endif
  );

  cv32e40x_rd_fifo_arb #(.N_REQ(4)) u4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v4), .req_data_i(d4), .req_gnt_o(gnt4),
    .fifo_push_o(push4), .fifo_data_o(fdata4), .fifo_full_i(zero), .fifo_empty_i(zero),
    .fifo_flush_o(flush4), .fifo_flush_but_first_o(fbf4), .kill_i(zero),
    .kill_keep_first_i(zero), .drain_req_i(zero), .drain_done_o(done4), .state_o(st4)
`ifdef CV32E40X_RD_FIFO_ARB_STATS_EN
    , .stat_grant_cnt_o(sg4), .stat_full_stall_cnt_o(ss4), .stat_kill_cnt_o(sk4)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; v2 = '0; d2 = '0; full = 1'b0; empty = 1'b0; kill = 1'b0; kkf = 1'b0;
    drain = 1'b0; v4 = '0; d4 = '0; zero = 1'b0;
    #2;
    chk("rst_state", 32'(st2), 32'd0);
    chk("rst_done", 32'(done2), 32'd0);
    chk("rst_push", 32'(push2), 32'd0);
    chk("rst_state4", 32'(st4), 32'd0);
    // Requests and kills while reset is held must produce nothing.
    v2 = 2'b11; kill = 1'b1; #1;
    chk("rst_gnt", 32'(gnt2), 32'd0);
    chk("rst_flush", 32'(flush2), 32'd0);
    kill = 1'b0; v2 = '0;
    tick; tick;
    rst = 1'b0;

    // Alternating grants with both requesters valid.
    d2[0] = 16'h0011; d2[1] = 16'h0022; v2 = 2'b11; #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_gnt", 32'(gnt2), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_push", 32'(push2), 32'd1);
      chk("rr_data", 32'(fdata2), (i % 2 == 0) ? 32'h11 : 32'h22);
      tick;
    end

    // FIFO full blocks requester 1 for three cycles.
    v2 = 2'b10; d2[1] = 16'h00A5; full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_gnt", 32'(gnt2), 32'd0);
      chk("full_push", 32'(push2), 32'd0);
      chk("full_data", 32'(fdata2), 32'd0);
      tick;
    end
    full = 1'b0; #1;
    chk("unfull_gnt", 32'(gnt2), 32'd2);
    chk("unfull_data", 32'(fdata2), 32'hA5);
    tick;

    // Simultaneous kill and keep-first: full flush wins, two grant-free cycles.
    v2 = 2'b11; kill = 1'b1; kkf = 1'b1; #1;
    chk("kill_flush", 32'(flush2), 32'd1);
    chk("kill_fbf", 32'(fbf2), 32'd0);
    chk("kill_gnt", 32'(gnt2), 32'd0);
    tick;
    kill = 1'b0; kkf = 1'b0; #1;
    chk("flush_state", 32'(st2), 32'd1);
    chk("flush_gnt", 32'(gnt2), 32'd0);
    chk("flush_nopulse", 32'(flush2), 32'd0);
    tick;
    chk("resume_state", 32'(st2), 32'd0);
    chk("resume_gnt0", 32'(gnt2), 32'd1);
    tick;
    chk("resume_gnt1", 32'(gnt2), 32'd2);
    tick;

    // Keep-first kill alone.
    kkf = 1'b1; #1;
    chk("kkf_fbf", 32'(fbf2), 32'd1);
    chk("kkf_flush", 32'(flush2), 32'd0);
    chk("kkf_gnt", 32'(gnt2), 32'd0);
    tick;
    kkf = 1'b0; #1;
    chk("kkf_state", 32'(st2), 32'd1);
    tick;

    // Drain with three entries popping out one per cycle.
    drain = 1'b1; empty = 1'b0; #1;
    chk("drain_req_gnt", 32'(gnt2), 32'd0);
    chk("drain_req_state", 32'(st2), 32'd0);
    tick;
    chk("drain_state", 32'(st2), 32'd2);
    chk("drain_push", 32'(push2), 32'd0);
    tick; tick;
    empty = 1'b1; #1;
    chk("drain_empty_state", 32'(st2), 32'd2);
    chk("drain_empty_done", 32'(done2), 32'd0);
    tick;
    chk("done_state", 32'(st2), 32'd3);
    chk("done_flag", 32'(done2), 32'd1);
    chk("done_gnt", 32'(gnt2), 32'd0);
    kill = 1'b1; #1;
    chk("done_kill_flush", 32'(flush2), 32'd1);
    tick;
    kill = 1'b0; #1;
    chk("done_kill_state", 32'(st2), 32'd3);
    drain = 1'b0; #1;
    chk("undrain_done_held", 32'(done2), 32'd1);
    tick;
    chk("undrain_state", 32'(st2), 32'd0);
    chk("undrain_done", 32'(done2), 32'd0);
    chk("undrain_gnt", 32'(gnt2), 32'd1);
    tick;

    // Pointer now at 1; re-enter DONE, then reset asynchronously.
    v2 = '0; drain = 1'b1;
    tick; tick;
    chk("pre_rst_state", 32'(st2), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(st2), 32'd0);
    chk("async_rst_done", 32'(done2), 32'd0);
    #1 rst = 1'b0; drain = 1'b0; v2 = 2'b11;
    #1;
    chk("post_rst_gnt", 32'(gnt2), 32'd1);
    tick;
    v2 = '0;

    // Four requesters, pointer wrap from 3 back to 0.
    d4[0] = 16'h0010; d4[1] = 16'h0011; d4[2] = 16'h0012; d4[3] = 16'h0013;
    v4 = 4'b1010; #1;
    chk("n4_gnt1", 32'(gnt4), 32'h2);
    chk("n4_data1", 32'(fdata4), 32'h11);
    tick;
    chk("n4_gnt3", 32'(gnt4), 32'h8);
    chk("n4_data3", 32'(fdata4), 32'h13);
    tick;
    v4 = 4'b1011; #1;
    chk("n4_wrap_gnt0", 32'(gnt4), 32'h1);
    chk("n4_state", 32'(st4), 32'd0);
    tick;
    v4 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
